// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target front end.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

  localparam logic RW_READ             = 1'b1;
  localparam int   ADDR_W              = 7;
  localparam int   SYNC_STAGES_DEFAULT = 2;

  // Command byte as it arrives on the wire: R/W in bit 7, address below it.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered rise/fall strobes; level q is aligned with the strobes.
// Pin edge to strobe latency: STAGES+1 clk cycles. No backpressure.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RST_VAL}};
      q     <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      q     <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~q;
      fall  <= ~chain[STAGES-1] & q;
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: decodes command byte + data bytes, streams tx_d out on miso.
// Strobes 1 cycle after the synchronized 8th sclk rise; no backpressure (host owns timing).
module spi_target
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              rw_out,
  output logic              addr_dv,
  output logic [7:0]        rx_d,
  output logic              rxdv,
  input  logic [7:0]        tx_d,
  input  logic              tx_en,
  output logic              tx_done,
  output logic              frame_abort
);

  logic       sclk_lvl_unused, sclk_rise, sclk_fall;
  logic       cs_q, cs_rise, cs_fall;
  logic       mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_state_t state;
  logic       armed;
  logic       tx_load;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] shift_nxt;
  logic [7:0] tx_sr;
  cmd_t       cmd;

  // cs_n chain resets low so a chip select already asserted at reset release
  // never looks like a frame start; the first observed rise arms the target.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .din(cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(sclk),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign shift_nxt = {shift_q[6:0], mosi_q};
  assign cmd       = cmd_t'(shift_nxt);
  assign miso      = tx_sr[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      tx_load     <= 1'b0;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      tx_sr       <= 8'h00;
      reg_addr    <= '0;
      rw_out      <= 1'b0;
      addr_dv     <= 1'b0;
      rx_d        <= 8'h00;
      rxdv        <= 1'b0;
      tx_done     <= 1'b0;
      frame_abort <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      rxdv        <= 1'b0;
      tx_done     <= 1'b0;
      frame_abort <= 1'b0;
      tx_load     <= 1'b0;
      miso_oe     <= armed & ~cs_q;

      if (cs_rise) begin
        armed       <= 1'b1;
        frame_abort <= (state != IDLE) && (bit_cnt != 3'd0);
        state       <= IDLE;
        bit_cnt     <= 3'd0;
        shift_q     <= 8'h00;
        tx_sr       <= 8'h00;
        reg_addr    <= '0;
        rw_out      <= 1'b0;
        addr_dv     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall && armed) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
              shift_q <= 8'h00;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              shift_q <= shift_nxt;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw_out   <= cmd.rw;
                reg_addr <= cmd.addr;
                addr_dv  <= 1'b1;
                tx_load  <= (cmd.rw == RW_READ);
                state    <= DATA;
              end
            end
          end

          DATA: begin
            // The fall that follows a byte's last rise must not shift: the
            // freshly loaded MSB has to be on miso for the next byte's first rise.
            if (tx_load)
              tx_sr <= tx_en ? tx_d : 8'h00;
            else if (sclk_fall && rw_out == RW_READ && bit_cnt != 3'd0)
              tx_sr <= {tx_sr[6:0], 1'b0};

            if (sclk_rise) begin
              shift_q <= shift_nxt;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rw_out == RW_READ) begin
                  tx_done <= 1'b1;
                  tx_load <= 1'b1;
                end else begin
                  rx_d <= shift_nxt;
                  rxdv <= 1'b1;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: host-side SPI driver, wrapper model for tx_d, scoreboard queues.
module tb_spi_target;
  import spi_pkg::*;

  localparam int HALF = 50;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso, miso_oe, rw_out, addr_dv, rxdv, tx_done, frame_abort;
  logic              tx_en = 1'b0;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        rx_d, tx_d;

  logic [7:0] tx_src [4];
  int         tx_done_cnt = 0;
  int         tx_base = 0;
  int         abort_cnt = 0;
  int         addr_dv_cnt = 0;
  int         total = 0;
  int         bad = 0;
  logic       addr_dv_d = 1'b0;

  logic [7:0] cmd_q [$];
  logic [7:0] rx_q  [$];
  logic [7:0] rd_q  [$];

  always #5 clk = ~clk;

  // Wrapper model: advances to the next source byte on every tx_done.
  assign tx_d = tx_src[2'(tx_done_cnt - tx_base)];

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .rw_out(rw_out),
    .addr_dv(addr_dv), .rx_d(rx_d), .rxdv(rxdv), .tx_d(tx_d), .tx_en(tx_en),
    .tx_done(tx_done), .frame_abort(frame_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (addr_dv && !addr_dv_d) begin
        addr_dv_cnt++;
        if (cmd_q.size() == 0) chk("addr_dv_unexpected", addr_dv, 1'b0);
        else begin
          logic [7:0] c;
          c = cmd_q.pop_front();
          chk("reg_addr", reg_addr, c[6:0]);
          chk("rw_out", rw_out, c[7]);
        end
      end
      if (rxdv) begin
        if (rx_q.size() == 0) chk("rxdv_unexpected", rxdv, 1'b0);
        else chk("rx_d", rx_d, rx_q.pop_front());
      end
      if (tx_done) tx_done_cnt++;
      if (frame_abort) abort_cnt++;
    end
    addr_dv_d = addr_dv;
  end

  task automatic xfer(input logic [7:0] dout, input int nbits, output logic [7:0] din);
    din = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = dout[i];
      #HALF sclk = 1'b1;
      din[i] = miso;
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic cs_lo;
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_hi;
    #HALF cs_n = 1'b1;
    #(HALF * 4);
  endtask

  task automatic host_read(input string tag);
    logic [7:0] got;
    xfer(8'h00, 8, got);
    if (rd_q.size() == 0) chk({tag, "_no_exp"}, rd_q.size(), 1);
    else chk(tag, got, rd_q.pop_front());
  endtask

  task automatic drained(input string tag);
    chk({tag, "_cmd_q"}, cmd_q.size(), 0);
    chk({tag, "_rx_q"}, rx_q.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dummy;
    int base_td, base_ab, base_dv;
    for (int i = 0; i < 4; i++) tx_src[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_addr_dv", addr_dv, 1'b0);
    chk("rst_rw_out", rw_out, 1'b0);
    chk("rst_reg_addr", reg_addr, 7'h00);
    chk("rst_rx_d", rx_d, 8'h00);
    chk("rst_rxdv", rxdv, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_frame_abort", frame_abort, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    #(HALF * 4);

    // Write frame: cmd 0x06, data 0xA5
    cmd_q.push_back(8'h06);
    rx_q.push_back(8'hA5);
    cs_lo();
    chk("wr_miso_oe_on", miso_oe, 1'b1);
    xfer(8'h06, 8, dummy);
    xfer(8'hA5, 8, dummy);
    cs_hi();
    chk("wr_addr_dv_clr", addr_dv, 1'b0);
    chk("wr_miso_oe_off", miso_oe, 1'b0);
    chk("wr_rx_d_hold", rx_d, 8'hA5);
    drained("wr");

    // Single read: cmd 0x87, tx_d 0x3C
    tx_src[0] = 8'h3C;
    tx_base = tx_done_cnt;
    tx_en = 1'b1;
    cmd_q.push_back(8'h87);
    rd_q.push_back(8'h3C);
    cs_lo();
    xfer(8'h87, 8, dummy);
    host_read("rd_byte");
    cs_hi();
    chk("rd_tx_done_cnt", tx_done_cnt - tx_base, 1);
    chk("rd_rx_d_hold", rx_d, 8'hA5);
    drained("rd");

    // Read burst: cmd 0x88, three streamed bytes
    tx_src[0] = 8'h11; tx_src[1] = 8'h22; tx_src[2] = 8'h33; tx_src[3] = 8'hEE;
    tx_base = tx_done_cnt;
    cmd_q.push_back(8'h88);
    for (int i = 0; i < 3; i++) rd_q.push_back(8'h11 * 8'(i + 1));
    cs_lo();
    xfer(8'h88, 8, dummy);
    for (int i = 0; i < 3; i++) host_read("burst_byte");
    cs_hi();
    chk("burst_tx_done_cnt", tx_done_cnt - tx_base, 3);
    drained("burst");

    // Read with tx_en low: all-ones mosi must not produce rxdv
    tx_src[0] = 8'hC3; tx_src[1] = 8'hC3;
    tx_base = tx_done_cnt;
    tx_en = 1'b0;
    cmd_q.push_back(8'hFF);
    rd_q.push_back(8'h00);
    cs_lo();
    xfer(8'hFF, 8, dummy);
    mosi = 1'b1;
    host_read("noen_byte");
    cs_hi();
    chk("noen_tx_done_cnt", tx_done_cnt - tx_base, 1);
    drained("noen");

    // Empty chip-select pulse: no abort
    base_ab = abort_cnt;
    cs_lo();
    cs_hi();
    chk("empty_frame_abort", abort_cnt - base_ab, 0);

    // Abort after 5 data bits of a write, then a clean frame
    base_ab = abort_cnt;
    cmd_q.push_back(8'h10);
    cs_lo();
    xfer(8'h10, 8, dummy);
    xfer(8'hF0, 5, dummy);
    cs_hi();
    chk("abort_pulse_cnt", abort_cnt - base_ab, 1);
    chk("abort_rx_d_hold", rx_d, 8'hA5);
    chk("abort_addr_dv_clr", addr_dv, 1'b0);
    cmd_q.push_back(8'h22);
    rx_q.push_back(8'h5A);
    cs_lo();
    xfer(8'h22, 8, dummy);
    xfer(8'h5A, 8, dummy);
    cs_hi();
    chk("post_abort_rx_d", rx_d, 8'h5A);
    chk("post_abort_no_abort", abort_cnt - base_ab, 1);
    drained("abort");

    // Reset asserted mid-read, cs_n held low afterwards
    tx_src[0] = 8'h3C;
    tx_base = tx_done_cnt;
    tx_en = 1'b1;
    cmd_q.push_back(8'h87);
    cs_lo();
    xfer(8'h87, 8, dummy);
    xfer(8'h00, 3, dummy);
    #20 reset_n = 1'b0;
    #3;
    chk("mid_rst_miso", miso, 1'b0);
    chk("mid_rst_miso_oe", miso_oe, 1'b0);
    chk("mid_rst_addr_dv", addr_dv, 1'b0);
    chk("mid_rst_rw_out", rw_out, 1'b0);
    chk("mid_rst_reg_addr", reg_addr, 7'h00);
    chk("mid_rst_rx_d", rx_d, 8'h00);
    chk("mid_rst_tx_done", tx_done, 1'b0);
    base_td = tx_done_cnt;
    base_dv = addr_dv_cnt;
    #30 reset_n = 1'b1;
    #(HALF * 2);
    xfer(8'h87, 8, dummy);
    xfer(8'h00, 8, dummy);
    chk("post_rst_miso_oe", miso_oe, 1'b0);
    chk("post_rst_addr_dv_cnt", addr_dv_cnt - base_dv, 0);
    chk("post_rst_tx_done_cnt", tx_done_cnt - base_td, 0);
    cs_hi();
    drained("mid_rst");

    // Recovery after reset
    cmd_q.push_back(8'h05);
    rx_q.push_back(8'h33);
    cs_lo();
    xfer(8'h05, 8, dummy);
    xfer(8'h33, 8, dummy);
    cs_hi();
    chk("recover_rx_d", rx_d, 8'h33);
    drained("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
